// File: rtl/btn_press_decoder.sv
// Button press classifier: short, long and double click events
// from a debounced level, plus hold level and saturating press count.
module btn_press_decoder #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned DCLICK_TICKS = 300,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             db_in,
  input  logic             count_clr,
  output logic             short_pulse,
  output logic             long_pulse,
  output logic             double_pulse,
  output logic             hold,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DMAX = (LONG_TICKS > DCLICK_TICKS)
                               ? LONG_TICKS : DCLICK_TICKS;
  localparam int unsigned DW   = (DMAX > 2) ? $clog2(DMAX) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] LONG_LAST = DW'(LONG_TICKS - 1);
  localparam logic [DW-1:0] DCLK_LAST = DW'(DCLICK_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HOLD,
    GAP,
    PRESS2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    dur_q, dur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q;
  logic             sp_q, sp_d;
  logic             lp_q, lp_d;
  logic             dp_q, dp_d;
  logic             hold_q, hold_d;

  logic rise, fall, tick;

  assign rise = db_in & ~db_q;
  assign fall = ~db_in & db_q;
  assign tick = (presc_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    sp_d    = 1'b0;
    lp_d    = 1'b0;
    dp_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          state_d = GAP;
        end else if (tick && dur_q == LONG_LAST) begin
          state_d = LONG_HOLD;
          lp_d    = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (fall) state_d = IDLE;
      end
      GAP: begin
        if (rise) begin
          state_d = PRESS2;
        end else if (tick && dur_q == DCLK_LAST) begin
          state_d = IDLE;
          sp_d    = 1'b1;
        end
      end
      PRESS2: begin
        // A long second press still settles the first click as short
        if (fall) begin
          state_d = IDLE;
          dp_d    = 1'b1;
        end else if (tick && dur_q == LONG_LAST) begin
          state_d = LONG_HOLD;
          sp_d    = 1'b1;
          lp_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    dur_d   = dur_q;
    if (state_d != state_q) begin
      dur_d = '0;
    end else if (tick && dur_q != '1) begin
      dur_d = dur_q + DW'(1);
    end
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (rise && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    hold_d = (state_d == LONG_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      dur_q   <= '0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      sp_q    <= 1'b0;
      lp_q    <= 1'b0;
      dp_q    <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dur_q   <= dur_d;
      cnt_q   <= cnt_d;
      db_q    <= db_in;
      sp_q    <= sp_d;
      lp_q    <= lp_d;
      dp_q    <= dp_d;
      hold_q  <= hold_d;
    end
  end

  assign short_pulse  = sp_q;
  assign long_pulse   = lp_q;
  assign double_pulse = dp_q;
  assign hold         = hold_q;
  assign press_count  = cnt_q;

endmodule

// File: doc/btn_press_decoder.md
Name: btn_press_decoder

Overview:
Sits directly downstream of the switch debouncer and consumes its clean level output `db`. Classifies each press into one of three single-cycle events: short press, long press or double click. Also provides a hold level and a saturating press counter. Intended for front-panel/user-button control of the datapath.

Parameters:
TICK_DIV, 50000, clk cycles per timing tick (prescaler period); must be >= 2
LONG_TICKS, 1000, ticks a press must last to count as long; must be >= 2
DCLICK_TICKS, 300, ticks allowed between first release and second press for a double click; must be >= 2
CNT_W, 8, width of press_count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
db_in  input  1  debounced button level from the debouncer (1 = pressed)
count_clr  input  1  synchronous clear of press_count
short_pulse  output  1  one-cycle pulse: single short click completed
long_pulse  output  1  one-cycle pulse: press reached long threshold
double_pulse  output  1  one-cycle pulse: double click completed
hold  output  1  level, high while a long press is still held
press_count  output  CNT_W  number of press rising edges, saturating

Behaviour:
- Reset: asynchronous, active-high; clock clk.
  - Reset values: state=IDLE, prescaler=0, dur=0, db_d=0, all outputs 0.
  - Reset mid-operation aborts any pending classification; no pulse is emitted.
- Edge detect: db_d registers db_in each cycle.
  - rise = db_in & ~db_d; fall = ~db_in & db_d.
- Prescaler:
  - Free-running 0..TICK_DIV-1, wraps to 0.
  - tick=1 for the single cycle where prescaler==TICK_DIV-1.
- dur (tick counter):
  - Cleared on every state transition.
  - Otherwise increments on tick; saturates at its max.
  - "timeout(N)" means tick & dur==N-1.
  - Timing resolution is one tick: actual thresholds fall between (N-1)*TICK_DIV+1 and N*TICK_DIV cycles.
- FSM, evaluated each clk; fall/rise take priority over timeout in the same cycle:
  - IDLE: rise -> PRESS1.
  - PRESS1:
    - fall -> GAP.
    - timeout(LONG_TICKS) -> LONG_HOLD, assert long_pulse.
  - LONG_HOLD: hold=1; fall -> IDLE. No other event is emitted on release.
  - GAP:
    - rise -> PRESS2.
    - timeout(DCLICK_TICKS) -> IDLE, assert short_pulse.
  - PRESS2:
    - fall -> IDLE, assert double_pulse.
    - timeout(LONG_TICKS) -> LONG_HOLD, assert short_pulse and long_pulse in the same cycle (first click was short, second is long).
  - Unreachable encodings -> IDLE.
- Output timing:
  - All outputs are registered.
  - Pulses go high on the same clk edge that commits the transition and stay high for exactly 1 cycle.
  - hold rises on the edge entering LONG_HOLD and falls on the edge leaving it.
- Latency: the event pulse appears 1 cycle after the db_in change is sampled (one db_d stage plus registered transition).
- press_count:
  - Increments on every rise, in any state.
  - Saturates at 2^CNT_W-1.
  - count_clr wins over a simultaneous rise, leaving the value 0.
- Mutual exclusion: at most one of short/long/double per transition, except the PRESS2 long case defined above.
- db_in is assumed glitch-free (already debounced). A rise in PRESS1 or PRESS2 is impossible without a prior fall and is ignored.

Test Plan:
All scenarios use TICK_DIV=4, LONG_TICKS=5, DCLICK_TICKS=3, CNT_W=2.
1. Reset values and async abort:
   - Assert reset → all outputs 0, press_count=0.
   - Assert reset while in PRESS1 → no pulse; state returns to IDLE at once.
2. Short press:
   - db_in high 6 cycles, then low.
   - Expect short_pulse exactly 1 cycle, between 9 and 12 cycles after the fall.
   - No long_pulse or double_pulse; press_count=1.
3. Long press:
   - db_in high 40 cycles.
   - Expect long_pulse 1 cycle, between 17 and 21 cycles after the rise.
   - hold stays high until 1 cycle after the fall.
   - No short_pulse on release.
4. Double click:
   - high 5 cycles, low 4 cycles, high 5 cycles, low.
   - Expect double_pulse 1 cycle after the second fall; no short_pulse; press_count=2.
5. Second press held long:
   - high 5, low 4, high 40.
   - Expect short_pulse and long_pulse together in one cycle; hold=1 until release.
6. press_count saturation and clear:
   - 5 short presses spaced 30 cycles apart → press_count saturates at 3.
   - count_clr asserted in the same cycle as a rise → press_count=0 afterwards.
